sobol_index_seq: RTL and testbench

Programmable index/dimension sequencer feeding `sobol_flex`. On `start` it emits every (path index, time-step dimension) pair of a simulation batch over a ready/valid stream, in path-major or dimension-major order. Its `idx_out`/`dim_out` connect directly to the Sobol generator's `idx_in`/`dim_in`, and its `valid_out`/`ready_in` connect to that generator's `valid_in`/`ready_out`. Start/busy/done status goes to the batch controller.

---
 rtl/fpga_cfg_pkg.sv | 9 +
 rtl/sobol_index_seq_if.sv | 18 +
 rtl/wrap_counter.sv | 38 +++
 rtl/sobol_index_seq.sv | 113 +++++++++++
 tb/tb_sobol_index_seq.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared configuration for the Sobol datapath: widths, dimension count and
// the index-sequencer state/order encodings.
package fpga_cfg_pkg;
  localparam int FP_WIDTH   = 32;
  localparam int SOBOL_DIMS = 50;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_DONE} seq_state_t;
  typedef enum logic {ORD_PATH_MAJOR, ORD_DIM_MAJOR} seq_order_t;
endpackage

// File: rtl/sobol_index_seq_if.sv
// Ready/valid stream of (path index, dimension) pairs from the sequencer to
// the Sobol generator.
interface sobol_index_seq_if #(
  parameter int WIDTH = fpga_cfg_pkg::FP_WIDTH,
  parameter int DW    = $clog2(fpga_cfg_pkg::SOBOL_DIMS)
);
  logic             valid_out;
  logic             ready_in;
  logic [WIDTH-1:0] idx_out;
  logic [DW-1:0]    dim_out;
  logic             last_dim;
  logic             last_path;

  modport master (output valid_out, idx_out, dim_out, last_dim, last_path,
                  input  ready_in);
  modport slave  (input  valid_out, idx_out, dim_out, last_dim, last_path,
                  output ready_in);
endinterface

// File: rtl/wrap_counter.sv
// Counter from 0 to an inclusive limit that wraps to 0; at_limit is a
// registered flag tracking cnt == limit.
module wrap_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         at_limit
);
  logic [W-1:0] cnt_reg, cnt_next;
  logic         at_limit_reg;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr)
      cnt_next = '0;
    else if (en)
      cnt_next = at_limit_reg ? '0 : cnt_reg + W'(1);
  end

  // limit must already hold its new value in the cycle clr is asserted
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      at_limit_reg <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      at_limit_reg <= (cnt_next == limit);
    end
  end

  assign cnt      = cnt_reg;
  assign at_limit = at_limit_reg;
endmodule

// File: rtl/sobol_index_seq.sv
// Emits every (path index, dimension) pair of a batch on a ready/valid stream,
// in path-major or dimension-major order, with start/busy/done status.
module sobol_index_seq
  import fpga_cfg_pkg::*;
#(
  parameter  int WIDTH = FP_WIDTH,
  parameter  int M     = SOBOL_DIMS,
  localparam int DW    = $clog2(M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] num_paths,
  input  logic [WIDTH-1:0] path_base,
  input  logic [DW-1:0]    num_dims_m1,
  input  logic             order,
  sobol_index_seq_if.master out_if,
  output logic             busy,
  output logic             done
);
  seq_state_t       state_reg, state_next;
  seq_order_t       order_reg;
  logic [WIDTH-1:0] base_reg, np_m1_reg, pcnt, path_limit;
  logic [DW-1:0]    dims_m1_reg, dims_m1_clamped, dcnt, dim_limit;
  logic             in_idle, in_run, accept, empty_start;
  logic             xfer, path_en, dim_en, path_last, dim_last, final_xfer;

  assign in_idle     = (state_reg == SEQ_IDLE);
  assign in_run      = (state_reg == SEQ_RUN);
  assign accept      = in_idle && start && !abort && (num_paths != '0);
  assign empty_start = in_idle && start && !abort && (num_paths == '0);
  assign xfer        = in_run && out_if.ready_in && !abort;
  assign final_xfer  = xfer && path_last && dim_last;

  assign dims_m1_clamped = (num_dims_m1 > DW'(M - 1)) ? DW'(M - 1) : num_dims_m1;

  // While idle the counters see the live config so the clear on start loads
  // a correct at_limit flag in the same edge the config is latched.
  assign path_limit = in_idle ? num_paths - WIDTH'(1) : np_m1_reg;
  assign dim_limit  = in_idle ? dims_m1_clamped : dims_m1_reg;

  always_comb begin
    path_en = 1'b0;
    dim_en  = 1'b0;
    if (order_reg == ORD_PATH_MAJOR) begin
      dim_en  = xfer;
      path_en = xfer && dim_last;
    end else begin
      path_en = xfer;
      dim_en  = xfer && path_last;
    end
  end

  wrap_counter #(.W(WIDTH)) u_path_cnt (
    .clk(clk), .rst(rst), .clr(accept), .en(path_en),
    .limit(path_limit), .cnt(pcnt), .at_limit(path_last)
  );

  wrap_counter #(.W(DW)) u_dim_cnt (
    .clk(clk), .rst(rst), .clr(accept), .en(dim_en),
    .limit(dim_limit), .cnt(dcnt), .at_limit(dim_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      base_reg    <= '0;
      np_m1_reg   <= '0;
      dims_m1_reg <= '0;
      order_reg   <= ORD_PATH_MAJOR;
    end else if (accept) begin
      base_reg    <= path_base;
      np_m1_reg   <= num_paths - WIDTH'(1);
      dims_m1_reg <= dims_m1_clamped;
      order_reg   <= seq_order_t'(order);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= SEQ_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = SEQ_IDLE;
    end else begin
      case (state_reg)
        SEQ_IDLE: begin
          if (accept)
            state_next = SEQ_RUN;
          else if (empty_start)
            state_next = SEQ_DONE;
        end
        SEQ_RUN:  if (final_xfer) state_next = SEQ_DONE;
        SEQ_DONE: state_next = SEQ_IDLE;
        default:  state_next = SEQ_IDLE;
      endcase
    end
  end

  // Outputs depend only on state/counter/config registers, never on ready_in.
  assign out_if.valid_out = in_run;
  assign out_if.idx_out   = in_run ? base_reg + pcnt : '0;
  assign out_if.dim_out   = in_run ? dcnt : '0;
  assign out_if.last_dim  = in_run && dim_last;
  assign out_if.last_path = in_run && path_last;
  assign busy             = in_run;
  assign done             = (state_reg == SEQ_DONE);
endmodule

// File: tb/tb_sobol_index_seq.sv
// Directed bench for sobol_index_seq: both orders, stalls, wrap/clamp,
// empty batch, abort and mid-batch reset.
module tb_sobol_index_seq;
  localparam int W  = 32;
  localparam int M  = 50;
  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          rst, start, abort, order, busy, done;
  logic [W-1:0]  num_paths, path_base;
  logic [DW-1:0] num_dims_m1;
  int            vec_cnt = 0;
  int            err_cnt = 0;

  sobol_index_seq_if #(.WIDTH(W), .DW(DW)) sif ();

  sobol_index_seq #(.WIDTH(W), .M(M)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_paths(num_paths), .path_base(path_base), .num_dims_m1(num_dims_m1),
    .order(order), .out_if(sif), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // {valid, busy, done, last_dim, last_path, dim, idx}
  function automatic logic [42:0] pack_obs();
    return {sif.valid_out, busy, done, sif.last_dim, sif.last_path, sif.dim_out, sif.idx_out};
  endfunction

  task automatic launch(input logic [W-1:0] np, input logic [W-1:0] base,
                        input logic [DW-1:0] dm1, input logic ord);
    @(negedge clk);
    num_paths = np; path_base = base; num_dims_m1 = dm1; order = ord; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [42:0] got;
    rst = 1'b1; start = 1'b0; abort = 1'b0; order = 1'b0; sif.ready_in = 1'b1;
    num_paths = '0; path_base = '0; num_dims_m1 = '0;
    repeat (3) @(negedge clk);
    got = pack_obs();
    vec_cnt++;
    if (got !== 43'h0) begin err_cnt++; $display("FAIL reset: got %h expected %h", got, 43'h0); end
    rst = 1'b0;
    @(negedge clk);
    got = pack_obs();
    vec_cnt++;
    if (got !== 43'h0) begin err_cnt++; $display("FAIL idle_after_reset: got %h expected %h", got, 43'h0); end
  endtask

  task automatic test_order0();
    int ei[6] = '{1, 1, 2, 2, 3, 3};
    int ed[6] = '{0, 1, 0, 1, 0, 1};
    logic [42:0] got, exp;
    sif.ready_in = 1'b1;
    launch(3, 1, 1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      exp = {1'b1, 1'b1, 1'b0, ed[i] == 1, ei[i] == 3, DW'(ed[i]), W'(ei[i])};
      got = pack_obs();
      vec_cnt++;
      $display("order0 xfer %0d idx=%0d dim=%0d", i, sif.idx_out, sif.dim_out);
      if (got !== exp) begin err_cnt++; $display("FAIL order0[%0d]: got %h expected %h", i, got, exp); end
      @(negedge clk);
    end
    exp = {3'b001, 40'h0};
    got = pack_obs();
    vec_cnt++;
    if (got !== exp) begin err_cnt++; $display("FAIL order0_done: got %h expected %h", got, exp); end
    @(negedge clk);
    got = pack_obs();
    vec_cnt++;
    if (got !== 43'h0) begin err_cnt++; $display("FAIL order0_idle: got %h expected %h", got, 43'h0); end
  endtask

  task automatic test_order1();
    int ei[6] = '{1, 2, 3, 1, 2, 3};
    int ed[6] = '{0, 0, 0, 1, 1, 1};
    logic [42:0] got, exp;
    sif.ready_in = 1'b1;
    launch(3, 1, 1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      exp = {1'b1, 1'b1, 1'b0, ed[i] == 1, ei[i] == 3, DW'(ed[i]), W'(ei[i])};
      got = pack_obs();
      vec_cnt++;
      $display("order1 xfer %0d idx=%0d dim=%0d", i, sif.idx_out, sif.dim_out);
      if (got !== exp) begin err_cnt++; $display("FAIL order1[%0d]: got %h expected %h", i, got, exp); end
      @(negedge clk);
    end
    exp = {3'b001, 40'h0};
    got = pack_obs();
    vec_cnt++;
    if (got !== exp) begin err_cnt++; $display("FAIL order1_done: got %h expected %h", got, exp); end
  endtask

  task automatic test_stalls();
    int exp_p = 0, exp_d = 0, xfers = 0, cyc = 0;
    logic [42:0] got, exp;
    sif.ready_in = 1'b0;
    launch(4, 10, 49, 1'b0);
    while (cyc < 2000) begin
      if (sif.valid_out !== 1'b1) break;
      exp = {1'b1, 1'b1, 1'b0, exp_d == 49, exp_p == 3, DW'(exp_d), W'(10 + exp_p)};
      got = pack_obs();
      vec_cnt++;
      if (got !== exp) begin err_cnt++; $display("FAIL stall[%0d]: got %h expected %h", cyc, got, exp); end
      sif.ready_in = 1'($urandom_range(0, 1));
      if (sif.ready_in) begin
        $display("stall xfer %0d idx=%0d dim=%0d", xfers, sif.idx_out, sif.dim_out);
        xfers++;
        if (exp_d == 49) begin exp_d = 0; exp_p++; end
        else exp_d++;
      end
      @(negedge clk);
      cyc++;
    end
    vec_cnt++;
    if (cyc >= 2000) begin err_cnt++; $display("FAIL stall_timeout: got %0d cycles required <2000", cyc); end
    vec_cnt++;
    if (xfers != 200) begin err_cnt++; $display("FAIL stall_count: got %0d required %0d", xfers, 200); end
    vec_cnt++;
    if (done !== 1'b1) begin err_cnt++; $display("FAIL stall_done: got %b required 1", done); end
    sif.ready_in = 1'b1;
  endtask

  task automatic test_wrap_clamp();
    logic [42:0] got, exp;
    logic [W-1:0] ei;
    sif.ready_in = 1'b1;
    launch(2, 32'hFFFF_FFFF, 63, 1'b0);
    for (int i = 0; i < 100; i++) begin
      ei  = (i < 50) ? 32'hFFFF_FFFF : 32'h0;
      exp = {1'b1, 1'b1, 1'b0, (i % 50) == 49, i >= 50, DW'(i % 50), ei};
      got = pack_obs();
      vec_cnt++;
      $display("wrap xfer %0d idx=%h dim=%0d", i, sif.idx_out, sif.dim_out);
      if (got !== exp) begin err_cnt++; $display("FAIL wrap[%0d]: got %h expected %h", i, got, exp); end
      @(negedge clk);
    end
    exp = {3'b001, 40'h0};
    got = pack_obs();
    vec_cnt++;
    if (got !== exp) begin err_cnt++; $display("FAIL wrap_done: got %h expected %h", got, exp); end
  endtask

  task automatic test_empty();
    logic [42:0] got, exp;
    launch(0, 5, 3, 1'b0);
    exp = {3'b001, 40'h0};
    got = pack_obs();
    vec_cnt++;
    if (got !== exp) begin err_cnt++; $display("FAIL empty_done: got %h expected %h", got, exp); end
    @(negedge clk);
    got = pack_obs();
    vec_cnt++;
    if (got !== 43'h0) begin err_cnt++; $display("FAIL empty_idle: got %h expected %h", got, 43'h0); end
  endtask

  task automatic test_abort();
    logic [42:0] got, exp;
    sif.ready_in = 1'b1;
    launch(3, 1, 1, 1'b0);
    repeat (4) @(negedge clk);
    exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 32'd3};
    got = pack_obs();
    vec_cnt++;
    if (got !== exp) begin err_cnt++; $display("FAIL abort_pre: got %h expected %h", got, exp); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    got = pack_obs();
    vec_cnt++;
    if (got !== 43'h0) begin err_cnt++; $display("FAIL abort_next: got %h expected %h", got, 43'h0); end
    @(negedge clk);
    got = pack_obs();
    vec_cnt++;
    if (got !== 43'h0) begin err_cnt++; $display("FAIL abort_nodone: got %h expected %h", got, 43'h0); end
    launch(1, 7, 0, 1'b0);
    exp = {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'd0, 32'd7};
    got = pack_obs();
    vec_cnt++;
    if (got !== exp) begin err_cnt++; $display("FAIL abort_restart: got %h expected %h", got, exp); end
    @(negedge clk);
    exp = {3'b001, 40'h0};
    got = pack_obs();
    vec_cnt++;
    if (got !== exp) begin err_cnt++; $display("FAIL abort_restart_done: got %h expected %h", got, exp); end
  endtask

  task automatic test_reset_mid();
    logic [42:0] got, exp;
    sif.ready_in = 1'b0;
    launch(2, 20, 2, 1'b1);
    exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'd20};
    got = pack_obs();
    vec_cnt++;
    if (got !== exp) begin err_cnt++; $display("FAIL mid_first: got %h expected %h", got, exp); end
    num_paths = 5; path_base = 100; num_dims_m1 = 0; order = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = pack_obs();
    vec_cnt++;
    if (got !== exp) begin err_cnt++; $display("FAIL mid_start_ignored: got %h expected %h", got, exp); end
    sif.ready_in = 1'b1;
    @(negedge clk);
    sif.ready_in = 1'b0;
    exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 32'd21};
    got = pack_obs();
    vec_cnt++;
    if (got !== exp) begin err_cnt++; $display("FAIL mid_second: got %h expected %h", got, exp); end
    rst = 1'b1;
    @(negedge clk);
    got = pack_obs();
    vec_cnt++;
    if (got !== 43'h0) begin err_cnt++; $display("FAIL mid_reset: got %h expected %h", got, 43'h0); end
    rst = 1'b0;
    @(negedge clk);
    got = pack_obs();
    vec_cnt++;
    if (got !== 43'h0) begin err_cnt++; $display("FAIL mid_reset_quiet: got %h expected %h", got, 43'h0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_order0();
    test_order1();
    test_stalls();
    test_wrap_clamp();
    test_empty();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
